// File: rtl/csr_access_controller.sv
// csr_access_controller: sequences CSRRW/RS/RC accesses into the CSR file; CSR_DEBUG_PORT_EN adds an arbitrated debug requester.
module csr_access_controller #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic [1:0]  core_op,
    input  logic [11:0] core_address,
    input  logic [31:0] core_writeData,
    input  logic        core_suppressRead,
    output logic        core_ack,
    output logic        core_error,
    output logic [31:0] core_readData,
`ifdef CSR_DEBUG_PORT_EN
    input  logic        dbg_req,
    input  logic [1:0]  dbg_op,
    input  logic [11:0] dbg_address,
    input  logic [31:0] dbg_writeData,
    output logic        dbg_ack,
    output logic        dbg_error,
    output logic [31:0] dbg_readData,
`endif
    output logic        csrReadEnable,
    output logic [11:0] csrReadAddress,
    input  logic [31:0] csrReadData,
    output logic        csrWriteEnable,
    output logic [11:0] csrWriteAddress,
    output logic [31:0] csrWriteData,
    output logic        busy
);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, ACK = 2'd3;
    localparam logic [1:0] OP_RW = 2'd1, OP_RS = 2'd2;
    logic [1:0]  state, op, in_op;
    logic [11:0] addr, in_addr;
    logic [31:0] wdata, in_wdata, old_value, rd_val, wr_val, ack_val;
    logic        sup, any_req, pick_dbg, grant_dbg;
    logic        no_read, write_needed, illegal, do_write, to_ack, ack_err;

`ifdef CSR_DEBUG_PORT_EN
    logic last_grant;
    assign any_req  = core_req | dbg_req;
    // last_grant=1 means debug was served last, so the core wins the next tie
    assign pick_dbg = dbg_req && (!core_req || FIXED_PRIORITY != 0 || !last_grant);
    assign in_op    = pick_dbg ? dbg_op : core_op;
    assign in_addr  = pick_dbg ? dbg_address : core_address;
    assign in_wdata = pick_dbg ? dbg_writeData : core_writeData;
    assign dbg_ack  = state == ACK && grant_dbg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_dbg    <= 1'b0;
            last_grant   <= 1'b1;
            dbg_readData <= '0;
            dbg_error    <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_dbg  <= pick_dbg;
                last_grant <= pick_dbg;
            end
            if (to_ack && grant_dbg) begin
                dbg_readData <= ack_val;
                dbg_error    <= ack_err;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = FIXED_PRIORITY != 0;
    assign any_req    = core_req;
    assign pick_dbg   = 1'b0;
    assign grant_dbg  = 1'b0;
    assign in_op      = core_op;
    assign in_addr    = core_address;
    assign in_wdata   = core_writeData;
`endif

    assign no_read      = sup && op == OP_RW;
    assign rd_val       = no_read ? '0 : csrReadData;
    assign write_needed = op == OP_RW || (op[1] && wdata != '0);
    assign illegal      = write_needed && addr[11:10] == 2'b11;
    assign do_write     = write_needed && !illegal;
    assign to_ack       = (state == READ && !do_write) || state == WRITE;
    assign ack_val      = state == READ ? rd_val : old_value;
    assign ack_err      = state == READ && illegal;
    assign wr_val       = op == OP_RW ? wdata : op == OP_RS ? (old_value | wdata) : (old_value & ~wdata);

    assign csrReadEnable   = state == READ && !no_read;
    assign csrReadAddress  = addr;
    assign csrWriteEnable  = state == WRITE;
    assign csrWriteAddress = addr;
    assign csrWriteData    = wr_val;
    assign core_ack        = state == ACK && !grant_dbg;
    assign busy            = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            op            <= '0;
            addr          <= '0;
            wdata         <= '0;
            sup           <= 1'b0;
            old_value     <= '0;
            core_readData <= '0;
            core_error    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    state <= READ;
                    op    <= in_op;
                    addr  <= in_addr;
                    wdata <= in_wdata;
                    sup   <= !pick_dbg && core_suppressRead;
                end
                READ: begin
                    old_value <= rd_val;
                    state     <= do_write ? WRITE : ACK;
                end
                WRITE: state <= ACK;
                default: state <= IDLE;
            endcase
            if (to_ack && !grant_dbg) begin
                core_readData <= ack_val;
                core_error    <= ack_err;
            end
        end
    end
endmodule

// File: tb/tb_csr_access_controller.sv
// tb_csr_access_controller: directed checks of CSR access sequencing, latency, protection and reset abort.
module tb_csr_access_controller;
    logic        clk = 1'b0, rst = 1'b1;
    logic        core_req = 1'b0, core_suppressRead = 1'b0;
    logic [1:0]  core_op = '0;
    logic [11:0] core_address = '0;
    logic [31:0] core_writeData = '0;
    logic        core_ack, core_error;
    logic [31:0] core_readData;
`ifdef CSR_DEBUG_PORT_EN
    logic        dbg_req = 1'b0;
    logic [1:0]  dbg_op = '0;
    logic [11:0] dbg_address = '0;
    logic [31:0] dbg_writeData = '0;
    logic        dbg_ack, dbg_error;
    logic [31:0] dbg_readData;
`endif
    logic        csrReadEnable, csrWriteEnable, busy;
    logic [11:0] csrReadAddress, csrWriteAddress;
    logic [31:0] csrReadData, csrWriteData;
    logic [31:0] csr_value = '0;
    int          vectors = 0, miscompares = 0, wr_count = 0;

    assign csrReadData = csr_value;
    always #5 clk = ~clk;
    always @(posedge clk) if (csrWriteEnable) wr_count <= wr_count + 1;

    csr_access_controller dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_op(core_op), .core_address(core_address),
        .core_writeData(core_writeData), .core_suppressRead(core_suppressRead),
        .core_ack(core_ack), .core_error(core_error), .core_readData(core_readData),
`ifdef CSR_DEBUG_PORT_EN
        .dbg_req(dbg_req), .dbg_op(dbg_op), .dbg_address(dbg_address),
        .dbg_writeData(dbg_writeData), .dbg_ack(dbg_ack), .dbg_error(dbg_error),
        .dbg_readData(dbg_readData),
`endif
        .csrReadEnable(csrReadEnable), .csrReadAddress(csrReadAddress), .csrReadData(csrReadData),
        .csrWriteEnable(csrWriteEnable), .csrWriteAddress(csrWriteAddress),
        .csrWriteData(csrWriteData), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_core(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d, input logic s);
        @(negedge clk);
        core_req = 1'b1; core_op = o; core_address = a; core_writeData = d; core_suppressRead = s;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({core_ack, core_error, core_readData, csrReadEnable, csrWriteEnable, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ack=%b err=%b rd=%h re=%b we=%b busy=%b, need all 0",
                     core_ack, core_error, core_readData, csrReadEnable, csrWriteEnable, busy);
        end
        vectors++;
        if ({csrReadAddress, csrWriteAddress, csrWriteData} !== '0) begin
            miscompares++;
            $display("FAIL reset_buses: ra=%h wa=%h wd=%h, need 0", csrReadAddress, csrWriteAddress, csrWriteData);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_csrrs;
        csr_value = 32'h0000_00F0;
        start_core(2'b10, 12'h340, 32'h0F, 1'b0);
        vectors++;
        if (csrReadEnable !== 1'b1 || csrReadAddress !== 12'h340 || csrWriteEnable !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rs_read_cycle: re=%b ra=%h we=%b busy=%b, need 1 340 0 1", csrReadEnable, csrReadAddress, csrWriteEnable, busy);
        end
        tick();
        vectors++;
        if (csrWriteEnable !== 1'b1 || csrWriteAddress !== 12'h340 || csrWriteData !== 32'h0000_00FF || csrReadEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL rs_write_cycle: we=%b wa=%h wd=%h re=%b, need 1 340 000000ff 0", csrWriteEnable, csrWriteAddress, csrWriteData, csrReadEnable);
        end
        tick();
        vectors++;
        if (core_ack !== 1'b1 || core_readData !== 32'h0000_00F0 || core_error !== 1'b0 || csrWriteEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL rs_ack: ack=%b rd=%h err=%b we=%b, need 1 000000f0 0 0", core_ack, core_readData, core_error, csrWriteEnable);
        end
        core_req = 1'b0;
        csr_value = 32'h1111_1111;
        tick();
        vectors++;
        if (core_ack !== 1'b0 || busy !== 1'b0 || core_readData !== 32'h0000_00F0) begin
            miscompares++;
            $display("FAIL rs_hold: ack=%b busy=%b rd=%h, need 0 0 000000f0", core_ack, busy, core_readData);
        end
    endtask

    task automatic test_csrrc_zero;
        csr_value = 32'h0000_1234;
        start_core(2'b11, 12'hC00, 32'h0, 1'b0);
        vectors++;
        if (csrReadEnable !== 1'b1 || csrReadAddress !== 12'hC00) begin
            miscompares++;
            $display("FAIL rc0_read: re=%b ra=%h, need 1 c00", csrReadEnable, csrReadAddress);
        end
        tick();
        vectors++;
        if (core_ack !== 1'b1 || csrWriteEnable !== 1'b0 || core_readData !== 32'h0000_1234 || core_error !== 1'b0) begin
            miscompares++;
            $display("FAIL rc0_ack: ack=%b we=%b rd=%h err=%b, need 1 0 00001234 0", core_ack, csrWriteEnable, core_readData, core_error);
        end
        core_req = 1'b0;
        tick();
    endtask

    task automatic test_csrrc_set_bits;
        csr_value = 32'h0000_00FF;
        start_core(2'b11, 12'h341, 32'h0F, 1'b0);
        tick();
        vectors++;
        if (csrWriteEnable !== 1'b1 || csrWriteData !== 32'h0000_00F0) begin
            miscompares++;
            $display("FAIL rc_write: we=%b wd=%h, need 1 000000f0", csrWriteEnable, csrWriteData);
        end
        tick();
        vectors++;
        if (core_ack !== 1'b1 || core_readData !== 32'h0000_00FF) begin
            miscompares++;
            $display("FAIL rc_ack: ack=%b rd=%h, need 1 000000ff", core_ack, core_readData);
        end
        core_req = 1'b0;
        tick();
    endtask

    task automatic test_readonly_write;
        int w0;
        w0 = wr_count;
        csr_value = 32'h0000_ABCD;
        start_core(2'b01, 12'hF15, 32'h1, 1'b0);
        vectors++;
        if (csrReadEnable !== 1'b1) begin
            miscompares++;
            $display("FAIL ro_read: re=%b, need 1", csrReadEnable);
        end
        tick();
        vectors++;
        if (core_ack !== 1'b1 || core_error !== 1'b1 || csrWriteEnable !== 1'b0 || core_readData !== 32'h0000_ABCD) begin
            miscompares++;
            $display("FAIL ro_ack: ack=%b err=%b we=%b rd=%h, need 1 1 0 0000abcd", core_ack, core_error, csrWriteEnable, core_readData);
        end
        core_req = 1'b0;
        tick();
        vectors++;
        if (wr_count !== w0 || core_error !== 1'b1) begin
            miscompares++;
            $display("FAIL ro_nowrite: writes=%0d err=%b, need %0d 1", wr_count - w0, core_error, 0);
        end
    endtask

    task automatic test_suppress_read;
        csr_value = 32'h5555_5555;
        start_core(2'b01, 12'h305, 32'hDEAD_BEEF, 1'b1);
        vectors++;
        if (csrReadEnable !== 1'b0 || csrWriteEnable !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL sup_read: re=%b we=%b busy=%b, need 0 0 1", csrReadEnable, csrWriteEnable, busy);
        end
        tick();
        vectors++;
        if (csrWriteEnable !== 1'b1 || csrWriteAddress !== 12'h305 || csrWriteData !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL sup_write: we=%b wa=%h wd=%h, need 1 305 deadbeef", csrWriteEnable, csrWriteAddress, csrWriteData);
        end
        tick();
        vectors++;
        if (core_ack !== 1'b1 || core_readData !== 32'h0 || core_error !== 1'b0) begin
            miscompares++;
            $display("FAIL sup_ack: ack=%b rd=%h err=%b, need 1 00000000 0", core_ack, core_readData, core_error);
        end
        core_req = 1'b0;
        tick();
        // suppressRead only applies to RW; a plain read must still strobe
        csr_value = 32'h0000_0077;
        start_core(2'b00, 12'h300, 32'h0, 1'b1);
        vectors++;
        if (csrReadEnable !== 1'b1) begin
            miscompares++;
            $display("FAIL sup_ignored_read: re=%b, need 1", csrReadEnable);
        end
        tick();
        vectors++;
        if (core_ack !== 1'b1 || core_readData !== 32'h0000_0077 || csrWriteEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL sup_ignored_ack: ack=%b rd=%h we=%b, need 1 00000077 0", core_ack, core_readData, csrWriteEnable);
        end
        core_req = 1'b0; core_suppressRead = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_write;
        int w0;
        csr_value = 32'h0000_0001;
        start_core(2'b01, 12'h340, 32'h99, 1'b0);
        tick();
        vectors++;
        if (csrWriteEnable !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_write: we=%b, need 1", csrWriteEnable);
        end
        core_req = 1'b0;
        rst = 1'b1;
        #1;
        w0 = wr_count;
        vectors++;
        if (csrWriteEnable !== 1'b0 || csrReadEnable !== 1'b0 || core_ack !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_abort: we=%b re=%b ack=%b busy=%b, need 0 0 0 0", csrWriteEnable, csrReadEnable, core_ack, busy);
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        vectors++;
        if (wr_count !== w0 || core_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_nowrite: writes=%0d ack=%b, need 0 0", wr_count - w0, core_ack);
        end
        csr_value = 32'h0000_0042;
        start_core(2'b00, 12'h344, 32'h0, 1'b0);
        tick();
        vectors++;
        if (core_ack !== 1'b1 || core_readData !== 32'h0000_0042) begin
            miscompares++;
            $display("FAIL rst_recover: ack=%b rd=%h, need 1 00000042", core_ack, core_readData);
        end
        core_req = 1'b0;
        tick();
    endtask

`ifdef CSR_DEBUG_PORT_EN
    task automatic test_back_to_back;
        string order;
        order = "";
        test_reset();
        csr_value = 32'h0000_0BAD;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            core_req = 1'b1; core_op = 2'b00; core_address = 12'h300; core_writeData = '0;
            dbg_req = 1'b1; dbg_op = 2'b00; dbg_address = 12'h301; dbg_writeData = '0;
            for (int c = 0; c < 12 && (core_req || dbg_req); c++) begin
                tick();
                if (core_ack && dbg_ack) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL arb_overlap: core_ack=%b dbg_ack=%b, need not both", core_ack, dbg_ack);
                end
                if (core_ack) begin order = {order, "C"}; core_req = 1'b0; end
                if (dbg_ack) begin
                    order = {order, "D"};
                    dbg_req = 1'b0;
                    vectors++;
                    if (dbg_readData !== 32'h0000_0BAD || dbg_error !== 1'b0) begin
                        miscompares++;
                        $display("FAIL arb_dbg_data: rd=%h err=%b, need 00000bad 0", dbg_readData, dbg_error);
                    end
                end
            end
            tick();
        end
        vectors++;
        if (order != "CDCD") begin
            miscompares++;
            $display("FAIL arb_order: got %s, need CDCD", order);
        end
        core_req = 1'b0; dbg_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_csrrs();
        test_csrrc_zero();
        test_csrrc_set_bits();
        test_readonly_write();
        test_suppress_read();
        test_reset_in_write();
`ifdef CSR_DEBUG_PORT_EN
        test_back_to_back();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
